// File: rtl/trace_stream_arbiter.sv
// Shares one character-stream checker between two trace sources.
// A source holds the grant for a whole '#'-terminated record. The checker's
// verdict is captured per record and counted per source in saturating counters.
module trace_stream_arbiter #(
  parameter int unsigned HOLD_MAX  = 64,
  parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_char,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_char,
  output logic        req1_ready,
  output logic [7:0]  chk_char,
  input  logic [1:0]  chk_format,
  output logic        rec_done,
  output logic        rec_src,
  output logic [1:0]  rec_type,
  output logic        rec_timeout,
  output logic [15:0] good0,
  output logic [15:0] bad0,
  output logic [15:0] good1,
  output logic [15:0] bad1
);

  localparam int unsigned   HW        = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [7:0]    END_CHAR  = 8'h23;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_RESULT} state_t;

  state_t        state, state_nx;
  logic          src, src_nx;
  logic          last, last_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [7:0]    char_nx;
  logic          done_nx, rsrc_nx, rto_nx;
  logic [1:0]    rtype_nx;
  logic          good_inc, bad_inc;
  logic          xfer;
  logic [7:0]    xchar;
  logic [15:0]   good0_q, bad0_q, good1_q, bad1_q;

  assign good0 = good0_q;
  assign bad0  = bad0_q;
  assign good1 = good1_q;
  assign bad1  = bad1_q;

  // Registered state, checker character and record result
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      src         <= 1'b0;
      last        <= 1'b1;
      hold_cnt    <= '0;
      chk_char    <= IDLE_CHAR;
      rec_done    <= 1'b0;
      rec_src     <= 1'b0;
      rec_type    <= 2'b00;
      rec_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      src         <= src_nx;
      last        <= last_nx;
      hold_cnt    <= hold_nx;
      chk_char    <= char_nx;
      rec_done    <= done_nx;
      rec_src     <= rsrc_nx;
      rec_type    <= rtype_nx;
      rec_timeout <= rto_nx;
    end
  end

  // Saturating per-source good/bad record counters
  always_ff @(posedge clk) begin
    if (reset) begin
      good0_q <= '0;
      bad0_q  <= '0;
      good1_q <= '0;
      bad1_q  <= '0;
    end else begin
      if (good_inc && !src && good0_q != '1) good0_q <= good0_q + 16'd1;
      if (bad_inc  && !src && bad0_q  != '1) bad0_q  <= bad0_q  + 16'd1;
      if (good_inc &&  src && good1_q != '1) good1_q <= good1_q + 16'd1;
      if (bad_inc  &&  src && bad1_q  != '1) bad1_q  <= bad1_q  + 16'd1;
    end
  end

  // Arbitration, forwarding and verdict capture
  always_comb begin
    state_nx   = state;
    src_nx     = src;
    last_nx    = last;
    hold_nx    = hold_cnt;
    char_nx    = IDLE_CHAR;
    done_nx    = 1'b0;
    rsrc_nx    = rec_src;
    rtype_nx   = rec_type;
    rto_nx     = rec_timeout;
    good_inc   = 1'b0;
    bad_inc    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer       = src ? req1_valid : req0_valid;
    xchar      = src ? req1_char  : req0_char;
    unique case (state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          src_nx   = (req0_valid && req1_valid) ? ~last : req1_valid;
          hold_nx  = '0;
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        req0_ready = !src;
        req1_ready = src;
        hold_nx    = hold_cnt + 1'b1;
        if (xfer) char_nx = xchar;
        // A '#' transfer wins over expiry on the last permitted cycle.
        if (xfer && xchar == END_CHAR) begin
          state_nx = S_DRAIN;
          last_nx  = src;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = S_IDLE;
          char_nx  = IDLE_CHAR;
          done_nx  = 1'b1;
          rsrc_nx  = src;
          rtype_nx = 2'b00;
          rto_nx   = 1'b1;
          bad_inc  = 1'b1;
          last_nx  = src;
        end
      end
      S_DRAIN: begin
        state_nx = S_RESULT;
      end
      S_RESULT: begin
        done_nx  = 1'b1;
        rsrc_nx  = src;
        rtype_nx = chk_format;
        rto_nx   = 1'b0;
        if (chk_format == 2'b01 || chk_format == 2'b10) good_inc = 1'b1;
        else bad_inc = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Bench for trace_stream_arbiter: queue-driven sources, a hash-based stand-in
// for the checker, and a record-level scoreboard of verdicts and counters.
module tb_trace_stream_arbiter;

  localparam int HOLD = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_char, req1_char, chk_char;
  logic [1:0]  chk_format, rec_type;
  logic        rec_done, rec_src, rec_timeout;
  logic [15:0] good0, bad0, good1, bad1;

  trace_stream_arbiter #(.HOLD_MAX(HOLD), .IDLE_CHAR(8'h00)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .chk_char(chk_char), .chk_format(chk_format),
    .rec_done(rec_done), .rec_src(rec_src), .rec_type(rec_type), .rec_timeout(rec_timeout),
    .good0(good0), .bad0(bad0), .good1(good1), .bad1(bad1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [1:0] ty;
    logic       to;
    int         at;
  } exp_t;

  string      rec_str [4];
  logic [1:0] rec_fmt [4];
  logic [7:0] q0[$], q1[$];
  int         p0[$], p1[$];
  exp_t       exp_q[$];
  int         lat_q[$];
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;
  int         quiet = 0;
  logic       prev_done = 1'b0;
  int         m_good [2];
  int         m_bad  [2];
  int         m_last = 1;
  logic [31:0] mk_hash;

  function automatic logic [31:0] hash_str(string s);
    logic [31:0] h = 32'd0;
    for (int i = 0; i < s.len() - 1; i++) h = h * 32'd31 + {24'd0, s[i]};
    return h;
  endfunction

  function automatic logic [1:0] lookup(logic [31:0] h);
    for (int i = 0; i < 4; i++) if (h == hash_str(rec_str[i])) return rec_fmt[i];
    return 2'b00;
  endfunction

  // Checker stand-in: recognises the known records by hash when '#' arrives
  always @(posedge clk) begin
    if (reset || chk_char == 8'h00) begin
      mk_hash    <= 32'd0;
      chk_format <= 2'b00;
    end else if (chk_char == 8'h23) begin
      mk_hash    <= 32'd0;
      chk_format <= lookup(mk_hash);
    end else begin
      mk_hash    <= mk_hash * 32'd31 + {24'd0, chk_char};
      chk_format <= 2'b00;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Source drivers: present the queue head, pop on handshake
  initial begin : drivers
    logic f0, f1;
    req0_valid = 1'b0; req0_char = 8'h00;
    req1_valid = 1'b0; req1_char = 8'h00;
    forever begin
      @(negedge clk);
      f0 = req0_valid && req0_ready;
      f1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      req0_valid = (q0.size() > 0);
      req0_char  = (q0.size() > 0) ? q0[0] : 8'h00;
      req1_valid = (q1.size() > 0);
      req1_char  = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // Scoreboard: latency, ready quiet window, verdicts and counters
  initial begin : monitor
    exp_t e;
    int   t;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
      end else begin
        if (quiet > 0) begin
          n_chk++;
          if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_quiet: got %b%b expected 00 at cyc %0d", req0_ready, req1_ready, cyc);
          end
          quiet--;
        end
        if ((req0_valid && req0_ready && req0_char == 8'h23) ||
            (req1_valid && req1_ready && req1_char == 8'h23)) begin
          lat_q.push_back(cyc + 3);
          quiet = 3;
        end
        if (rec_done === 1'b1) begin
          n_chk++;
          if (prev_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got 1 expected 0 in previous cycle at cyc %0d", cyc);
          end
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got rec_done src=%0d type=%0b expected none", rec_src, rec_type);
          end else begin
            e = exp_q.pop_front();
            if (e.to == 1'b0) begin
              t = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
              n_chk++;
              if (cyc !== t) begin
                n_fail++;
                $display("FAIL done_latency: got cyc %0d expected %0d", cyc, t);
              end
            end
            if (e.at >= 0) begin
              n_chk++;
              if (cyc !== e.at) begin
                n_fail++;
                $display("FAIL timeout_latency: got cyc %0d expected %0d", cyc, e.at);
              end
            end
            if (e.ty == 2'b01 || e.ty == 2'b10) begin
              if (m_good[e.src] < 65535) m_good[e.src]++;
            end else begin
              if (m_bad[e.src] < 65535) m_bad[e.src]++;
            end
            n_chk++;
            if (rec_src !== e.src[0] || rec_type !== e.ty || rec_timeout !== e.to) begin
              n_fail++;
              $display("FAIL rec_fields: got src=%0d type=%b to=%b expected src=%0d type=%b to=%b",
                       rec_src, rec_type, rec_timeout, e.src, e.ty, e.to);
            end
            n_chk++;
            if (good0 !== 16'(m_good[0]) || bad0 !== 16'(m_bad[0]) ||
                good1 !== 16'(m_good[1]) || bad1 !== 16'(m_bad[1])) begin
              n_fail++;
              $display("FAIL counters: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                       good0, bad0, good1, bad1, m_good[0], m_bad[0], m_good[1], m_bad[1]);
            end
          end
        end
        prev_done = rec_done;
      end
    end
  end

  task automatic push_rec(input int src, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (src == 0) q0.push_back(s[i]);
      else q1.push_back(s[i]);
    end
  endtask

  task automatic push_fill(input int src, input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) q0.push_back(c);
      else q1.push_back(c);
    end
    if (src == 0) q0.push_back(8'h23);
    else q1.push_back(8'h23);
  endtask

  task automatic add_exp(input int src, input logic [1:0] ty, input logic to, input int at);
    exp_t e;
    e.src = src; e.ty = ty; e.to = to; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int lim);
    for (int i = 0; i < lim && exp_q.size() > 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0 || lat_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_complete: got %0d records and %0d verdicts outstanding expected 0",
               name, exp_q.size(), lat_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // Record-level round robin: with both sources holding records, the one not
  // served last goes next; otherwise whichever still has records.
  task automatic run_pair(input string name);
    int i0 = 0, i1 = 0, s;
    foreach (p0[k]) push_rec(0, rec_str[p0[k]]);
    foreach (p1[k]) push_rec(1, rec_str[p1[k]]);
    while (i0 < p0.size() || i1 < p1.size()) begin
      if (i0 < p0.size() && i1 < p1.size()) s = (m_last == 1) ? 0 : 1;
      else s = (i0 < p0.size()) ? 0 : 1;
      if (s == 0) begin add_exp(0, rec_fmt[p0[i0]], 1'b0, -1); i0++; end
      else        begin add_exp(1, rec_fmt[p1[i1]], 1'b0, -1); i1++; end
      m_last = s;
    end
    wait_done(name, 60 * (p0.size() + p1.size() + 1));
  endtask

  task automatic check_idle_outputs(input string name);
    n_chk++;
    if (chk_char !== 8'h00 || rec_done !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got char=%h done=%b rdy=%b%b expected 00 0 00",
               name, chk_char, rec_done, req0_ready, req1_ready);
    end
    n_chk++;
    if (good0 !== 16'd0 || bad0 !== 16'd0 || good1 !== 16'd0 || bad1 !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_counters: got %0d/%0d/%0d/%0d expected 0/0/0/0", name, good0, bad0, good1, bad1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    n_chk++;
    if (rec_src !== 1'b0 || rec_type !== 2'b00 || rec_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rec: got src=%b type=%b to=%b expected 0 00 0", rec_src, rec_type, rec_timeout);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    p0.delete(); p1.delete();
    p0.push_back(0);
    run_pair("single");
  endtask

  task automatic test_alternate();
    p0.delete(); p1.delete();
    p0.push_back(1); p0.push_back(1);
    p1.push_back(0); p1.push_back(2);
    run_pair("alternate");
  endtask

  task automatic test_malformed();
    p0.delete(); p1.delete();
    p1.push_back(3);
    run_pair("malformed");
  endtask

  task automatic test_timeout();
    int t0;
    push_rec(0, "^12");
    @(negedge clk);
    t0 = cyc;
    add_exp(0, 2'b00, 1'b1, t0 + HOLD + 1);
    m_last = 0;
    repeat (2) @(negedge clk);
    push_rec(1, rec_str[0]);
    add_exp(1, 2'b01, 1'b0, -1);
    m_last = 1;
    wait_done("timeout", 3 * HOLD + 100);
  endtask

  task automatic test_hold_boundary();
    push_fill(1, 8'h61, HOLD - 1);
    push_fill(1, 8'h62, HOLD);
    add_exp(1, 2'b00, 1'b0, -1);
    add_exp(1, 2'b00, 1'b1, -1);
    add_exp(1, 2'b00, 1'b0, -1);
    m_last = 1;
    wait_done("hold_boundary", 4 * HOLD + 100);
  endtask

  task automatic test_random();
    int n0, n1;
    for (int it = 0; it < 6; it++) begin
      p0.delete(); p1.delete();
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(1, 3);
      for (int k = 0; k < n0; k++) p0.push_back($urandom_range(0, 3));
      for (int k = 0; k < n1; k++) p1.push_back($urandom_range(0, 3));
      run_pair("random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    force dut.good0_q = 16'hFFFF;
    @(negedge clk);
    release dut.good0_q;
    m_good[0] = 65535;
    p0.delete(); p1.delete();
    p0.push_back(1);
    run_pair("saturate");
  endtask

  task automatic test_reset_mid();
    push_rec(0, rec_str[1]);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    q0.delete(); q1.delete();
    exp_q.delete(); lat_q.delete();
    quiet = 0;
    m_good[0] = 0; m_good[1] = 0; m_bad[0] = 0; m_bad[1] = 0;
    m_last = 1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    p0.delete(); p1.delete();
    p0.push_back(0);
    p1.push_back(1);
    run_pair("after_reset");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rec_str[0] = "^10@00003000: $5 <= 0000abcd#";
    rec_str[1] = "^7@0000300c: *00001000 <= 12345678#";
    rec_str[2] = "^2@00003004: $6 <= 00001234#";
    rec_str[3] = "^10@0000300: $5 <= 0000abcd#";
    rec_fmt[0] = 2'b01;
    rec_fmt[1] = 2'b10;
    rec_fmt[2] = 2'b01;
    rec_fmt[3] = 2'b00;
    m_good[0] = 0; m_good[1] = 0; m_bad[0] = 0; m_bad[1] = 0;
    test_reset();
    test_single();
    test_alternate();
    test_malformed();
    test_timeout();
    test_hold_boundary();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_stream_arbiter.md
# trace_stream_arbiter

Shares one `cpu_checker` instance between two CPU trace sources that each emit character-stream records terminated by `#`. The block grants one source at a time for a whole record and forwards its characters to the checker. It captures the checker's `format_type` verdict for that record and keeps per-source good/bad record counters. It sits between the two trace emitters and the checker's `char` / `format_type` ports.

## Interface
Parameters:
- `HOLD_MAX`, default 64: maximum cycles a grant may be held in GRANT without a `#` transfer before forced release.
- `IDLE_CHAR`, default 8'h00: character driven to the checker when no record is being forwarded. It must drive the checker back to its initial state.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; clears all state on the posedge where it is high.
- `req0_valid`  in  1  source 0 has a character.
- `req0_char`  in  8  source 0 character.
- `req0_ready`  out  1  source 0 character is accepted this cycle.
- `req1_valid`, `req1_char`, `req1_ready`  same semantics for source 1.
- `chk_char`  out  8  registered character to the checker's `char` input.
- `chk_format`  in  2  checker `format_type` (00 error, 01 register record, 10 memory record).
- `rec_done`  out  1  one-cycle pulse when a record verdict is final.
- `rec_src`  out  1  source of the completed record; valid while `rec_done` is high.
- `rec_type`  out  2  verdict (forced 00 on timeout); valid while `rec_done` is high.
- `rec_timeout`  out  1  record ended by `HOLD_MAX` expiry; valid while `rec_done` is high.
- `good0`, `bad0`, `good1`, `bad1`  out  16 each  saturating per-source counts. Good means verdict 01 or 10. Bad means verdict 00 or timeout.

## Operation
- State machine states: IDLE, GRANT, DRAIN, RESULT.
- IDLE:
  - `chk_char` <= `IDLE_CHAR`.
  - Both ready outputs are low.
  - If either valid is high, choose a source, set `src`, clear `hold_cnt`, and go to GRANT.
  - Arbitration is round-robin. With both valid, grant the source != `last`. With one valid, grant that one.
- GRANT:
  - `reqN_ready` = (`src`==N), combinational.
  - A transfer is `valid && ready`. On a transfer, `chk_char` <= the transferred char. Otherwise `chk_char` <= `IDLE_CHAR`; a stall corrupts the record and the checker reports it.
  - `hold_cnt` increments every cycle in GRANT.
  - Transfer of `#`: go to DRAIN and set `last` <= `src`.
  - Else, if `hold_cnt` == `HOLD_MAX`-1:
    - go to IDLE with `chk_char` <= `IDLE_CHAR`;
    - next cycle, pulse `rec_done` with `rec_type`=00, `rec_timeout`=1;
    - increment `bad[src]`;
    - set `last` <= `src`.
- DRAIN:
  - `#` is on `chk_char` for this cycle, and the checker consumes it at the closing edge.
  - `chk_char` <= `IDLE_CHAR`; go to RESULT.
- RESULT:
  - `chk_format` now reflects the record, and is sampled at the closing edge.
  - Register `rec_done`=1, `rec_src`=`src`, `rec_type`=`chk_format`, `rec_timeout`=0.
  - Increment `good[src]` if the verdict is 01 or 10, else `bad[src]`.
  - Go to IDLE.
- Counters saturate at 16'hFFFF and never wrap.
- Ready outputs are low in IDLE, DRAIN and RESULT.

## Timing
- Reset values:
  - state IDLE, `last`=1 (source 0 wins the first contention);
  - `chk_char`=`IDLE_CHAR`;
  - `rec_done`=0, `rec_src`=0, `rec_type`=00, `rec_timeout`=0;
  - all counters 0, `hold_cnt`=0.
- Reset mid-record abandons the record with no `rec_done` and no counter update.
- IDLE to first possible transfer: 1 cycle (the grant is registered).
- Latency from the `#` transfer edge E0:
  - `#` on `chk_char` in cycle E0..E1;
  - verdict sampled at E2;
  - `rec_done` high in cycle E2..E3, i.e. 2 cycles after the transfer edge, for exactly one cycle.
- Minimum gap between records from alternating sources: back-to-back grant is possible in the cycle after RESULT (IDLE lasts 1 cycle).
- Timeout: at most `HOLD_MAX` cycles in GRANT per grant.
- A characters-after-`#` stream from the same source waits for re-arbitration.

## Test plan
- Source 0 only, 1-char/cycle, sends `^10@00003000: $5 <= 0000abcd#` -> one `rec_done`, `rec_src`=0, `rec_type`=01, `good0`=1, `req0_ready` low during DRAIN/RESULT/IDLE.
- Both sources valid continuously. Src0 sends a memory record `^7@0000300c: *00001000 <= 12345678#`; src1 sends a register record -> grants alternate 0,1,0,1; verdicts 10 and 01; `good0`=`good1`=2 after 4 records.
- Source 1 sends a malformed record (7 hex digits in the PC) ending `#` -> `rec_type`=00, `rec_timeout`=0, `bad1`=1.
- `HOLD_MAX`=8; source 0 sends `^12` then drops valid -> after 8 GRANT cycles return to IDLE, `rec_done` with `rec_timeout`=1, `bad0`=1; source 1 then granted next.
- Reset asserted while the GRANT state holds mid-record -> next cycle IDLE, `chk_char`=00, counters 0, no `rec_done`.
- Preload `good0`=16'hFFFF via 65535 good records (or a forced value in simulation), send one more good record -> stays 16'hFFFF.
